// File: rtl/memc_pixel_streamer.sv
// memc_pixel_streamer: streams 64x64 raster-order SRAM frames as 8x8-block-order pixels with back-pressure
// Optional build macro: MEMC_PS_FRAME_GAP_EN inserts FRAME_GAP idle read cycles between frames.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i, num_frames_i run request (IDLE only) and frame count, clamped to MAX_FRAMES
//   busy_i                consumer back-pressure; transfer when pixel_valid_o & ~busy_i
//   sram_ren_o/addr_o     SRAM read request; sram_rdata_i valid the cycle after
//   pixel_valid_o/pixel_o output pixel with its frame_idx_o and block_idx_o tags
//   done_o                one-cycle pulse after the last transfer of a run
module memc_pixel_streamer #(
   parameter int MAX_FRAMES = 10
`ifdef MEMC_PS_FRAME_GAP_EN
   , parameter int FRAME_GAP = 16
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [3:0]  num_frames_i,
   input  logic        busy_i,
   output logic        sram_ren_o,
   output logic [15:0] sram_addr_o,
   input  logic [7:0]  sram_rdata_i,
   output logic        pixel_valid_o,
   output logic [7:0]  pixel_o,
   output logic [3:0]  frame_idx_o,
   output logic [5:0]  block_idx_o,
   output logic        done_o
);
   localparam logic [3:0] MAXF = 4'(MAX_FRAMES);
   typedef enum logic [2:0] {
      IDLE,
      STREAM,
`ifdef MEMC_PS_FRAME_GAP_EN
      GAP,
`endif
      DRAIN,
      DONE
   } state_t;
   state_t      state_q, state_d;
   logic [3:0]  nf_q, nf_d, f_q, f_d, nf_clamp;
   // block-order pixel counter {by, bx, r, c}
   logic [11:0] cnt_q, cnt_d;
   // buffered words are {frame, block, pixel}
   logic [17:0] out_q, out_d, sk_q, sk_d;
   logic        out_v_q, out_v_d, sk_v_q, sk_v_d, infl_q;
   logic [9:0]  if_tag_q;
   logic        xfer, ren;
   logic [1:0]  lvl;
`ifdef MEMC_PS_FRAME_GAP_EN
   localparam int GW = $clog2(FRAME_GAP + 1);
   logic [GW-1:0] gap_q, gap_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) gap_q <= '0;
      else gap_q <= gap_d;
`endif
   assign nf_clamp      = (num_frames_i > MAXF) ? MAXF : num_frames_i;
   assign sram_ren_o    = ren;
   assign sram_addr_o   = ren ? {f_q, cnt_q[11:9], cnt_q[5:3], cnt_q[8:6], cnt_q[2:0]} : '0;
   assign pixel_valid_o = out_v_q;
   assign pixel_o       = out_q[7:0];
   assign block_idx_o   = out_q[13:8];
   assign frame_idx_o   = out_q[17:14];
   assign done_o        = (state_q == DONE);
   // returning data goes to the output register when it is free, otherwise to the skid slot
   always_comb begin
      xfer    = out_v_q & ~busy_i;
      lvl     = 2'(out_v_q) + 2'(sk_v_q) + 2'(infl_q);
      out_v_d = out_v_q;
      out_d   = out_q;
      sk_v_d  = sk_v_q;
      sk_d    = sk_q;
      if (xfer || !out_v_q) begin
         out_v_d = sk_v_q | infl_q;
         out_d   = sk_v_q ? sk_q : {if_tag_q, sram_rdata_i};
         sk_v_d  = sk_v_q & infl_q;
         sk_d    = {if_tag_q, sram_rdata_i};
      end else if (infl_q) begin
         sk_v_d = 1'b1;
         sk_d   = {if_tag_q, sram_rdata_i};
      end
   end
   always_comb begin
      state_d = state_q;
      nf_d    = nf_q;
      f_d     = f_q;
      cnt_d   = cnt_q;
      ren     = 1'b0;
`ifdef MEMC_PS_FRAME_GAP_EN
      gap_d   = gap_q;
`endif
      case (state_q)
         IDLE: if (start_i) begin
            nf_d    = nf_clamp;
            f_d     = '0;
            cnt_d   = '0;
            state_d = (nf_clamp == 4'd0) ? DONE : STREAM;
         end
         STREAM: begin
            ren = (lvl <= 2'd1) || (xfer && lvl != 2'd3);
            if (ren) begin
               cnt_d = cnt_q + 12'd1;
               if (&cnt_q) begin
                  f_d = f_q + 4'd1;
`ifdef MEMC_PS_FRAME_GAP_EN
                  state_d = (f_q == nf_q - 4'd1) ? DRAIN : GAP;
`else
                  state_d = (f_q == nf_q - 4'd1) ? DRAIN : STREAM;
`endif
               end
            end
         end
`ifdef MEMC_PS_FRAME_GAP_EN
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GW'(FRAME_GAP - 1)) begin
               gap_d   = '0;
               state_d = STREAM;
            end
         end
`endif
         DRAIN: state_d = (!out_v_d && !sk_v_d) ? DONE : DRAIN;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         nf_q     <= '0;
         f_q      <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         out_v_q  <= 1'b0;
         sk_q     <= '0;
         sk_v_q   <= 1'b0;
         infl_q   <= 1'b0;
         if_tag_q <= '0;
      end else begin
         state_q  <= state_d;
         nf_q     <= nf_d;
         f_q      <= f_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         out_v_q  <= out_v_d;
         sk_q     <= sk_d;
         sk_v_q   <= sk_v_d;
         infl_q   <= ren;
         if_tag_q <= ren ? {f_q, cnt_q[11:6]} : if_tag_q;
      end
endmodule

// File: tb/tb_memc_pixel_streamer.sv
// tb_memc_pixel_streamer: self-checking bench for memc_pixel_streamer with SRAM model and block-order reference
module tb_memc_pixel_streamer;
   logic        clk = 1'b0;
   logic        rst_n, start_i, busy_i;
   logic [3:0]  num_frames_i;
   logic        sram_ren_o;
   logic [15:0] sram_addr_o;
   logic [7:0]  sram_rdata_i;
   logic        pixel_valid_o;
   logic [7:0]  pixel_o;
   logic [3:0]  frame_idx_o;
   logic [5:0]  block_idx_o;
   logic        done_o;
   typedef struct {
      logic [3:0] nf;
      int         pct;
      int         mode;
      int         exp_n;
   } vec_t;
`ifdef MEMC_PS_FRAME_GAP_EN
   localparam int GAPX = 16;
`else
   localparam int GAPX = 0;
`endif
   int tests = 0, fails = 0;
   int cyc = 0, t0 = 0, busy_pct = 0, mode = 0;
   int nx, nren, ndone, bad, stall_bad, maxf, last_blk, first_n, done_n, last_xfer_n, ga, gb, first_addr, last_addr;
   logic        prev_stall = 1'b0;
   logic [17:0] prev_word;
   logic [7:0]  p0, p8, p64;
   vec_t        vecs[4];
   memc_pixel_streamer dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_frames_i(num_frames_i), .busy_i(busy_i),
      .sram_ren_o(sram_ren_o), .sram_addr_o(sram_addr_o), .sram_rdata_i(sram_rdata_i),
      .pixel_valid_o(pixel_valid_o), .pixel_o(pixel_o), .frame_idx_o(frame_idx_o),
      .block_idx_o(block_idx_o), .done_o(done_o)
   );
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [7:0] mem_val(input int a, input int m);
      return (m == 0) ? 8'(a % 256) : 8'((a * 7 + (a / 256) * 13 + 5) % 256);
   endfunction
   // n-th pixel of a run: frame, then 8x8 block in raster order, then raster order inside the block
   function automatic logic [17:0] exp_word(input int idx, input int m);
      int f, k, blk, p, a;
      f   = idx / 4096;
      k   = idx % 4096;
      blk = k / 64;
      p   = k % 64;
      a   = f * 4096 + ((blk / 8) * 8 + p / 8) * 64 + (blk % 8) * 8 + p % 8;
      return {4'(f), 6'(blk), mem_val(a, m)};
   endfunction
   always @(posedge clk) sram_rdata_i <= sram_ren_o ? mem_val(int'(sram_addr_o), mode) : 8'($urandom);
   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask
   task automatic chk_min(input string nm, input longint act, input longint lo);
      tests++;
      if (act < lo) begin
         fails++;
         $display("FAIL %s: got %0d, want at least %0d", nm, act, lo);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      #2;
   endtask
   initial forever begin
      int n;
      logic [17:0] w;
      @(negedge clk);
      busy_i = (int'($urandom_range(99)) < busy_pct);
      #1;
      if (rst_n) begin
         n = cyc - t0;
         w = {frame_idx_o, block_idx_o, pixel_o};
         if (prev_stall && (!pixel_valid_o || w != prev_word)) stall_bad++;
         prev_stall = 1'b0;
         if (sram_ren_o) begin
            if (nren == 0) first_addr = int'(sram_addr_o);
            last_addr = int'(sram_addr_o);
            nren++;
         end
         if (done_o) begin
            ndone++;
            done_n = n;
         end
         if (pixel_valid_o && !busy_i) begin
            if (w != exp_word(nx, mode)) bad++;
            if (nx == 0) begin first_n = n; p0 = pixel_o; end
            if (nx == 8) p8 = pixel_o;
            if (nx == 64) p64 = pixel_o;
            if (nx == 4095) ga = n;
            if (nx == 4096) gb = n;
            if (int'(frame_idx_o) > maxf) maxf = int'(frame_idx_o);
            last_blk    = int'(block_idx_o);
            last_xfer_n = n;
            nx++;
         end else if (pixel_valid_o) begin
            prev_stall = 1'b1;
            prev_word  = w;
         end
      end
   end
   task automatic clear_run();
      nx = 0; nren = 0; ndone = 0; bad = 0; stall_bad = 0; maxf = 0; last_blk = -1;
      first_n = -1; done_n = -1; last_xfer_n = -1; ga = 0; gb = 0; first_addr = -1; last_addr = -1;
      prev_stall = 1'b0; p0 = 8'hff; p8 = 8'hff; p64 = 8'hff;
   endtask
   task automatic launch(input logic [3:0] nf);
      start_i = 1'b1;
      num_frames_i = nf;
      @(posedge clk);
      t0 = cyc;
      tick();
      start_i = 1'b0;
      num_frames_i = 4'($urandom);
   endtask
   task automatic run_case(input vec_t v, input int id);
      string pfx;
      int frames, lim;
      pfx = $sformatf("run%0d", id);
      frames = v.exp_n / 4096;
      busy_pct = v.pct;
      mode = v.mode;
      clear_run();
      launch(v.nf);
      lim = v.exp_n * 3 + 200;
      for (int i = 0; i < lim && ndone == 0; i++) begin
         tick();
         start_i = (i == 50);
      end
      start_i = 1'b0;
      repeat (8) tick();
      chk({pfx, "_xfers"}, nx, v.exp_n);
      chk({pfx, "_pixel_errs"}, bad, 0);
      chk({pfx, "_stall_errs"}, stall_bad, 0);
      chk({pfx, "_done_pulses"}, ndone, 1);
      chk({pfx, "_reads"}, nren, v.exp_n);
      chk({pfx, "_idle_valid"}, pixel_valid_o, 0);
      if (v.exp_n == 0) chk({pfx, "_done_cycle"}, done_n, 1);
      else begin
         chk({pfx, "_done_after_last"}, done_n, last_xfer_n + 1);
         chk({pfx, "_first_addr"}, first_addr, 0);
         chk({pfx, "_last_addr"}, last_addr, v.exp_n - 1);
         chk({pfx, "_max_frame"}, maxf, frames - 1);
         chk({pfx, "_last_block"}, last_blk, 63);
      end
      if (v.pct == 0 && v.exp_n > 0) begin
         chk({pfx, "_first_latency"}, first_n, 3);
         chk({pfx, "_done_latency"}, done_n, v.exp_n + 3 + GAPX * (frames - 1));
      end
      if (v.mode == 0 && v.exp_n > 0) begin
         chk({pfx, "_pix1"}, p0, 8'h00);
         chk({pfx, "_pix9"}, p8, 8'h40);
         chk({pfx, "_pix65"}, p64, 8'h08);
      end
      if (v.pct == 0 && v.exp_n > 4096) begin
`ifdef MEMC_PS_FRAME_GAP_EN
         chk_min({pfx, "_frame_gap"}, gb - ga - 1, 14);
`else
         chk({pfx, "_frame_gap"}, gb - ga - 1, 0);
`endif
      end
   endtask
   initial begin
      vecs[0] = '{nf: 4'd1,  pct: 0,  mode: 0, exp_n: 4096};
      vecs[1] = '{nf: 4'd2,  pct: 50, mode: 1, exp_n: 8192};
      vecs[2] = '{nf: 4'd15, pct: 0,  mode: 1, exp_n: 40960};
      vecs[3] = '{nf: 4'd0,  pct: 0,  mode: 0, exp_n: 0};
      rst_n = 1'b0;
      start_i = 1'b0;
      busy_i = 1'b0;
      num_frames_i = '0;
      clear_run();
      tick();
      tick();
      chk("rst_ren", sram_ren_o, 0);
      chk("rst_addr", sram_addr_o, 0);
      chk("rst_valid", pixel_valid_o, 0);
      chk("rst_pixel", pixel_o, 0);
      chk("rst_frame", frame_idx_o, 0);
      chk("rst_block", block_idx_o, 0);
      chk("rst_done", done_o, 0);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) run_case(vecs[i], i);
      busy_pct = 30;
      mode = 1;
      clear_run();
      launch(4'd3);
      for (int i = 0; i < 20000 && nx < 1000; i++) tick();
      chk_min("midrun_progress", nx, 1000);
      busy_pct = 100;
      repeat (3) tick();
      chk("stall_valid", pixel_valid_o, 1);
      chk("stall_busy", busy_i, 1);
      prev_stall = 1'b0;
      ndone = 0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", pixel_valid_o, 0);
      chk("async_rst_ren", sram_ren_o, 0);
      chk("async_rst_frame", frame_idx_o, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      busy_pct = 0;
      repeat (10) tick();
      chk("post_rst_no_done", ndone, 0);
      chk("post_rst_idle_ren", sram_ren_o, 0);
      run_case('{nf: 4'd1, pct: 0, mode: 0, exp_n: 4096}, 4);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/memc_pixel_streamer.md
# memc_pixel_streamer

Source-side driver for the MEMC pixel input interface. It reads 64×64 8-bit frames from an external frame SRAM stored in raster order and reorders them into 8×8-block order. It presents them one pixel per cycle on `pixel_valid`/`pixel` and stalls whenever the MEMC consumer raises `busy`. It sits between the frame store and the motion-estimation core and sequences up to 10 frames per run.

## Interface
- `MAX_FRAMES`, 10: upper bound on frames per run; larger `num_frames` values are clamped to this.
- `FRAME_GAP`, 16: idle cycles inserted between frames (only with `MEMC_PS_FRAME_GAP_EN`).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle run request; sampled only in IDLE.
- `num_frames`  in  4  frames to send, latched on an accepted `start`.
- `busy`  in  1  consumer back-pressure; a transfer occurs on an edge where `pixel_valid`=1 and `busy`=0.
- `sram_ren`  out  1  SRAM read enable.
- `sram_addr`  out  16  SRAM byte address.
- `sram_rdata`  in  8  read data, valid exactly one cycle after the `sram_ren` cycle.
- `pixel_valid`  out  1  `pixel` holds a valid sample.
- `pixel`  out  8  pixel value.
- `frame_idx`  out  4  index of the frame whose pixel is on `pixel`, 0-based.
- `block_idx`  out  6  block index of the current `pixel`, `by*8+bx`.
- `done`  out  1  one-cycle pulse after the last transfer of the run.

## Operation
- **Reset values.** All outputs are 0. State is IDLE, all counters are 0, and both buffer slots are empty.
- **States and transitions.**
  - IDLE → STREAM on `start` with clamped `num_frames` ≠ 0.
  - IDLE → DONE on `start` with `num_frames`=0.
  - STREAM → GAP after the last read of a non-final frame (gap build only).
  - GAP → STREAM after `FRAME_GAP` cycles.
  - STREAM → DRAIN after the last read of the last frame.
  - DRAIN → DONE when both buffer slots are empty and the final transfer has occurred.
  - DONE → IDLE unconditionally, one cycle later.
- **Read ordering.** Nested counters: frame f, block row by, block column bx, pixel row r, pixel column c. c is the fastest-changing counter, f the slowest.
- **Address.** `sram_addr` = f·4096 + (by·8+r)·64 + bx·8 + c, computed in 16 bits. The maximum value is 40959.
- **Buffering.** The output register plus one skid slot hold at most 2 pixels. `sram_ren` is issued in a cycle only if (occupied slots + in-flight read) ≤ 1, or if a transfer is happening this cycle and that sum is ≤ 2. The buffer never overflows.
- **Stall behaviour.** While `busy`=1 with `pixel_valid`=1, `pixel`, `frame_idx` and `block_idx` hold stable. Data returning during a stall lands in the skid slot.
- **Tag tracking.** `frame_idx`/`block_idx` travel with each pixel through the buffer.
- **Ignored inputs.** `start` outside IDLE is ignored; `num_frames` changes after acceptance are ignored.
- **Wrap-around.**
  - c=7 → c=0, r+1.
  - r=7 → r=0, bx+1.
  - bx=7 → bx=0, by+1.
  - by=7 → by=0, f+1.
  - No reads are issued once f reaches the latched count.

## Timing
- **Start latency.** `start` sampled at edge E0. `sram_ren`=1 with address 0 in the cycle after E0. The first `pixel_valid`=1 appears in the cycle after E2, which is 3 cycles of latency.
- **Throughput.** 1 pixel/cycle with `busy` held low, i.e. 4096 consecutive transfers per frame and no bubbles across block boundaries.
- **Stall release.** When `busy` falls, transfers resume on the next edge with no bubble, because the skid slot covers the SRAM latency.
- **Completion.** `done` is high in the cycle after DRAIN empties.
  - Normal run: the cycle after the edge of the last transfer.
  - `num_frames`=0: the cycle after E0, with no reads issued.
- **Asynchronous reset mid-run.** All outputs clear immediately. Any in-flight SRAM data is discarded, and no `done` is produced.

## Configuration
- **`MEMC_PS_FRAME_GAP_EN` defined:**
  - After the last read of each non-final frame, no reads are issued for `FRAME_GAP` cycles (GAP state).
  - Buffered pixels still drain during the gap.
  - `pixel_valid` is low for at least `FRAME_GAP`-2 cycles between frames with `busy` low.
- **Not defined:** the GAP state and its counter are absent, and frames stream back-to-back with no bubble.

## Test plan
- **Single frame, no back-pressure.** `num_frames`=1, SRAM[a]=a[7:0], `busy`=0.
  - 4096 transfers, contiguous.
  - 1st pixel = 0x00, 9th pixel = SRAM[64] = 0x40, 65th pixel = SRAM[8] = 0x08.
  - `done` pulses 4099 cycles after the `start` edge.
- **Random back-pressure.** `busy` random at 50%, 2 frames.
  - 8192 transfers in exact block order.
  - `pixel` stable across every stall; no pixel lost or duplicated.
- **Maximum frames and clamping.** `num_frames`=15 → exactly 40960 transfers.
  - Last address read = 40959.
  - `frame_idx` runs 0..9.
  - Final `block_idx`=63.
- **Zero frames.** `num_frames`=0 → no `sram_ren`, no `pixel_valid`, and `done`=1 in the cycle after `start`.
- **Reset during a stall.** Assert `rst_n`=0 mid-frame while `busy`=1.
  - `pixel_valid`=0 immediately.
  - A new `start` restarts at address 0.
- **Gap build (`MEMC_PS_FRAME_GAP_EN`, `FRAME_GAP`=16, `busy`=0).** `pixel_valid` is low for ≥14 cycles between pixel 4096 and pixel 4097.
